vending_machine_multi: RTL

//   Parametrised multi-item successor to the single-soda vending FSM. Accepts nickel/dime/quarter

---
 rtl/vending_machine_multi.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: saturating coin credit, N_ITEMS products, greedy change over valid/ack.
// Optional per-item inventory tracking is enabled with `define VM_INVENTORY_EN.
module vending_machine_multi #(
  parameter int N_ITEMS    = 4,
  parameter int PRICE      = 4,
  parameter int MAX_CREDIT = 20,
  parameter int STOCK_INIT = 8,
  localparam int SEL_W     = $clog2(N_ITEMS),
  localparam int CREDIT_W  = $clog2(MAX_CREDIT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nickle,
  input  logic                dime,
  input  logic                quarter,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  input  logic                refund,
  input  logic                chg_ack,
  output logic                vend,
  output logic [SEL_W-1:0]    vend_item,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [N_ITEMS-1:0]  sold_out
);

  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [SEL_W:0]      ITEMS_LIM = (SEL_W + 1)'(N_ITEMS);

  typedef enum logic [1:0] {S_ACCEPT, S_VEND, S_CHANGE} state_t;
  state_t state;

  logic                coin_any;
  logic                coin_multi;
  logic [2:0]          coin_val;
  logic [CREDIT_W:0]   credit_sum;
  logic                item_avail;
  logic                buy_ok;
  logic [CREDIT_W-1:0] chg_left;

  // Largest coin that still fits in the remaining credit.
  function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(5))      return 2'b11;
    else if (c >= CREDIT_W'(2)) return 2'b10;
    else                        return 2'b01;
  endfunction

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      2'b11:   return 3'd5;
      2'b10:   return 3'd2;
      2'b01:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

`ifdef VM_INVENTORY_EN
  assign item_avail = !sold_out[sel];
`else
  assign item_avail = 1'b1;
`endif

  always_comb begin
    coin_any   = nickle | dime | quarter;
    coin_multi = (nickle & dime) | (nickle & quarter) | (dime & quarter);
    coin_val   = quarter ? 3'd5 : dime ? 3'd2 : nickle ? 3'd1 : 3'd0;
    credit_sum = {1'b0, credit} + (CREDIT_W + 1)'(coin_val);
    buy_ok     = buy && (credit >= PRICE_C) && ({1'b0, sel} < ITEMS_LIM) && item_avail;
    chg_left   = credit - CREDIT_W'(coin_value(chg_coin));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_ACCEPT;
      credit    <= '0;
      vend      <= 1'b0;
      vend_item <= '0;
      chg_valid <= 1'b0;
      chg_coin  <= 2'b00;
      coin_rej  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      vend     <= 1'b0;
      coin_rej <= 1'b0;
      case (state)
        S_ACCEPT: begin
          if (buy_ok) begin
            state     <= S_VEND;
            vend      <= 1'b1;
            vend_item <= sel;
            credit    <= credit - PRICE_C;
            busy      <= 1'b1;
            coin_rej  <= coin_any;
          end else if (refund && credit != '0) begin
            state     <= S_CHANGE;
            chg_valid <= 1'b1;
            chg_coin  <= pick_coin(credit);
            busy      <= 1'b1;
            coin_rej  <= coin_any;
          end else if (coin_multi) begin
            coin_rej <= 1'b1;
          end else if (coin_any) begin
            if (credit_sum > MAX_C) coin_rej <= 1'b1;
            else                    credit   <= credit_sum[CREDIT_W-1:0];
          end
        end
        S_VEND: begin
          coin_rej <= coin_any;
          if (credit != '0) begin
            state     <= S_CHANGE;
            chg_valid <= 1'b1;
            chg_coin  <= pick_coin(credit);
          end else begin
            state <= S_ACCEPT;
            busy  <= 1'b0;
          end
        end
        S_CHANGE: begin
          coin_rej <= coin_any;
          if (chg_ack && chg_valid) begin
            credit <= chg_left;
            if (chg_left == '0) begin
              state     <= S_ACCEPT;
              chg_valid <= 1'b0;
              chg_coin  <= 2'b00;
              busy      <= 1'b0;
            end else begin
              chg_coin <= pick_coin(chg_left);
            end
          end
        end
        default: begin
          state     <= S_ACCEPT;
          chg_valid <= 1'b0;
          chg_coin  <= 2'b00;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef VM_INVENTORY_EN
  localparam int STOCK_W = $clog2(STOCK_INIT + 1);
  logic [STOCK_W-1:0] stock [N_ITEMS];

  // sold_out is updated on the same edge as the decrement so the next buy already sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        stock[i]    <= STOCK_W'(STOCK_INIT);
        sold_out[i] <= 1'b0;
      end
    end else if (state == S_ACCEPT && buy_ok) begin
      stock[sel]    <= stock[sel] - STOCK_W'(1);
      sold_out[sel] <= (stock[sel] == STOCK_W'(1));
    end
  end
`else
  assign sold_out = '0;
`endif

endmodule
